// File: rtl/vc_crossbar3_arb.sv
// vc_crossbar3_arb: control end of a 3x3 crossbar.
// Each output runs its own round-robin arbiter over three val/rdy inputs.
// A packet lock keeps a multi-flit packet from being interleaved on an output.
// Arbitration is combinational, so a flit can be granted and moved in the
// cycle it is presented.
// Optional feature: define VC_CROSSBAR3_ARB_FLOW_CHECK_EN to refuse grants
// from domain-1 inputs to domain-0 outputs and to raise a sticky flow_violation.
module vc_crossbar3_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic       in0_val,
    input  logic       in1_val,
    input  logic       in2_val,
    output logic       in0_rdy,
    output logic       in1_rdy,
    output logic       in2_rdy,
    input  logic [1:0] in0_dest,
    input  logic [1:0] in1_dest,
    input  logic [1:0] in2_dest,
    input  logic       in0_last,
    input  logic       in1_last,
    input  logic       in2_last,
    input  logic       in0_domain,
    input  logic       in1_domain,
    input  logic       in2_domain,
    output logic       out0_val,
    output logic       out1_val,
    output logic       out2_val,
    input  logic       out0_rdy,
    input  logic       out1_rdy,
    input  logic       out2_rdy,
    input  logic       out0_domain,
    input  logic       out1_domain,
    input  logic       out2_domain,
    output logic [1:0] sel0,
    output logic [1:0] sel1,
    output logic [1:0] sel2,
    output logic       flow_violation
);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t     st_q    [3];
    logic [1:0] owner_q [3];
    logic [1:0] ptr_q   [3];
    logic [1:0] sel_q   [3];

    logic [2:0] in_val;
    logic [2:0] in_last;
    logic [2:0] out_rdy;
    logic [1:0] in_dest [3];

    logic [2:0] grant_val;
    logic [1:0] grant_sel [3];
    logic [2:0] xfer;
    logic [2:0] in_rdy;

    assign in_val     = {in2_val, in1_val, in0_val};
    assign in_last    = {in2_last, in1_last, in0_last};
    assign out_rdy    = {out2_rdy, out1_rdy, out0_rdy};
    assign in_dest[0] = in0_dest;
    assign in_dest[1] = in1_dest;
    assign in_dest[2] = in2_dest;

`ifdef VC_CROSSBAR3_ARB_FLOW_CHECK_EN
    logic [2:0] in_dom;
    logic [2:0] out_dom;
    logic       blocked_any;
    logic       fv_q;

    assign in_dom  = {in2_domain, in1_domain, in0_domain};
    assign out_dom = {out2_domain, out1_domain, out0_domain};
`else
    logic unused_domains;

    assign unused_domains = ^{in0_domain, in1_domain, in2_domain,
                              out0_domain, out1_domain, out2_domain};
`endif

    // Modulo-3 increment; the pointer never reaches 3.
    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Round-robin pick starting at base: {found, index}.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] base);
        logic [1:0] i0;
        logic [1:0] i1;
        logic [1:0] i2;
        i0 = base;
        i1 = inc3(i0);
        i2 = inc3(i1);
        if (r[i0])      return {1'b1, i0};
        else if (r[i1]) return {1'b1, i1};
        else if (r[i2]) return {1'b1, i2};
        return 3'b000;
    endfunction

    // Per-output grant: locked owner, or round-robin winner among requests.
    always_comb begin
        logic [2:0] req_v;
        logic [2:0] pick;
        in_rdy = 3'b000;
        for (int m = 0; m < 3; m++) begin
            req_v = 3'b000;
            for (int n = 0; n < 3; n++) begin
`ifdef VC_CROSSBAR3_ARB_FLOW_CHECK_EN
                req_v[n] = in_val[n] && (in_dest[n] == 2'(m)) && !(in_dom[n] && !out_dom[m]);
`else
                req_v[n] = in_val[n] && (in_dest[n] == 2'(m));
`endif
            end
            pick = rr_pick(req_v, ptr_q[m]);
            if (st_q[m] == ST_LOCKED) begin
                grant_val[m] = in_val[owner_q[m]];
                grant_sel[m] = owner_q[m];
            end else begin
                grant_val[m] = pick[2];
                grant_sel[m] = pick[2] ? pick[1:0] : sel_q[m];
            end
            // nothing moves in a reset cycle
            if (reset) begin
                grant_val[m] = 1'b0;
                grant_sel[m] = 2'd0;
            end
            xfer[m] = grant_val[m] && out_rdy[m];
            for (int n = 0; n < 3; n++) begin
                if (xfer[m] && (grant_sel[m] == 2'(n))) in_rdy[n] = 1'b1;
            end
        end
    end

    // Lock/unlock and pointer advance on each transfer; remember last grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int m = 0; m < 3; m++) begin
                st_q[m]    <= ST_IDLE;
                owner_q[m] <= 2'd0;
                ptr_q[m]   <= 2'd0;
                sel_q[m]   <= 2'd0;
            end
        end else begin
            for (int m = 0; m < 3; m++) begin
                if (grant_val[m]) sel_q[m] <= grant_sel[m];
                if (xfer[m]) begin
                    if (in_last[grant_sel[m]]) begin
                        st_q[m]  <= ST_IDLE;
                        ptr_q[m] <= inc3(grant_sel[m]);
                    end else begin
                        st_q[m]    <= ST_LOCKED;
                        owner_q[m] <= grant_sel[m];
                    end
                end
            end
        end
    end

`ifdef VC_CROSSBAR3_ARB_FLOW_CHECK_EN
    // Spot a high-to-low request at an idle output; locked packets are not re-checked.
    always_comb begin
        blocked_any = 1'b0;
        for (int m = 0; m < 3; m++) begin
            for (int n = 0; n < 3; n++) begin
                if ((st_q[m] == ST_IDLE) && in_val[n] && (in_dest[n] == 2'(m)) &&
                    in_dom[n] && !out_dom[m]) begin
                    blocked_any = 1'b1;
                end
            end
        end
    end

    // Sticky violation flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)            fv_q <= 1'b0;
        else if (blocked_any) fv_q <= 1'b1;
    end

    assign flow_violation = fv_q;
`else
    assign flow_violation = 1'b0;
`endif

    assign out0_val = grant_val[0];
    assign out1_val = grant_val[1];
    assign out2_val = grant_val[2];
    assign sel0     = grant_sel[0];
    assign sel1     = grant_sel[1];
    assign sel2     = grant_sel[2];
    assign in0_rdy  = in_rdy[0];
    assign in1_rdy  = in_rdy[1];
    assign in2_rdy  = in_rdy[2];

endmodule
